rf_cmd_ctrl: RTL and testbench

//  Command-driven initiator for the 4-read/2-write register file (regfile).

---
 rtl/rfc_pkg.sv | 31 +++
 rtl/rf_cmd_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_rf_cmd_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfc_pkg.sv
// -----------------------------------------------------------------------------
// rfc_pkg
//  Shared types and default sizes for the regfile command controller.
//  - rfc_op_t    : command opcode carried on cmd_op
//  - rfc_state_t : controller FSM states (VERIFY exists only when
//                  RFC_VERIFY_EN is defined)
//  - RFC_DATAWIDTH / RFC_ADDRWIDTH : default register and index widths
// -----------------------------------------------------------------------------
package rfc_pkg;

    localparam int RFC_DATAWIDTH = 32;
    localparam int RFC_ADDRWIDTH = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_SWAP  = 2'b11
    } rfc_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_WB     = 3'd2,
        ST_RESP   = 3'd3
`ifdef RFC_VERIFY_EN
        , ST_VERIFY = 3'd4
`endif
    } rfc_state_t;

endpackage

// File: rtl/rf_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rf_cmd_ctrl
//  Command-driven master of a 4-read/2-write register file. Accepts one
//  command (READ, WRITE, COPY, SWAP) on a valid/ready channel, drives the
//  regfile ports, and returns the result on a valid/ready response channel.
//
//  Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_addr0..3,
//   cmd_data0..1                command payload, latched on accept
//   rsp_valid/rsp_ready         response handshake (held until consumed)
//   rsp_data0..3, rsp_err       response payload
//   rf_write, rf_readReg1..4,
//   rf_writeReg1..2,
//   rf_writeData1..2            regfile control outputs
//   rf_readData1..4             regfile read data (combinational, bypassed)
//
//  Build option
//   RFC_VERIFY_EN : WRITE reads back its targets in an extra VERIFY state and
//                   flags any mismatch on rsp_err. Undefined: rsp_err is 0.
// -----------------------------------------------------------------------------
module rf_cmd_ctrl
    import rfc_pkg::*;
#(
    parameter int DATAWIDTH = RFC_DATAWIDTH,
    parameter int ADDRWIDTH = RFC_ADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDRWIDTH-1:0] cmd_addr0,
    input  logic [ADDRWIDTH-1:0] cmd_addr1,
    input  logic [ADDRWIDTH-1:0] cmd_addr2,
    input  logic [ADDRWIDTH-1:0] cmd_addr3,
    input  logic [DATAWIDTH-1:0] cmd_data0,
    input  logic [DATAWIDTH-1:0] cmd_data1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data0,
    output logic [DATAWIDTH-1:0] rsp_data1,
    output logic [DATAWIDTH-1:0] rsp_data2,
    output logic [DATAWIDTH-1:0] rsp_data3,
    output logic                 rsp_err,
    output logic                 rf_write,
    output logic [ADDRWIDTH-1:0] rf_readReg1,
    output logic [ADDRWIDTH-1:0] rf_readReg2,
    output logic [ADDRWIDTH-1:0] rf_readReg3,
    output logic [ADDRWIDTH-1:0] rf_readReg4,
    output logic [ADDRWIDTH-1:0] rf_writeReg1,
    output logic [ADDRWIDTH-1:0] rf_writeReg2,
    output logic [DATAWIDTH-1:0] rf_writeData1,
    output logic [DATAWIDTH-1:0] rf_writeData2,
    input  logic [DATAWIDTH-1:0] rf_readData1,
    input  logic [DATAWIDTH-1:0] rf_readData2,
    input  logic [DATAWIDTH-1:0] rf_readData3,
    input  logic [DATAWIDTH-1:0] rf_readData4
);

    rfc_state_t           state_reg, state_next;
    rfc_op_t              op_reg, op_next;
    logic [ADDRWIDTH-1:0] addr_reg [4];
    logic [ADDRWIDTH-1:0] addr_next [4];
    logic [ADDRWIDTH-1:0] cmd_addr [4];
    logic [DATAWIDTH-1:0] data_reg [2];
    logic [DATAWIDTH-1:0] data_next [2];
    logic [DATAWIDTH-1:0] tmp_reg [2];
    logic [DATAWIDTH-1:0] tmp_next [2];
    logic [DATAWIDTH-1:0] rsp_data_reg [4];
    logic [DATAWIDTH-1:0] rsp_data_next [4];
    logic [DATAWIDTH-1:0] rd_data [4];

    assign cmd_addr[0] = cmd_addr0;
    assign cmd_addr[1] = cmd_addr1;
    assign cmd_addr[2] = cmd_addr2;
    assign cmd_addr[3] = cmd_addr3;

    assign rd_data[0] = rf_readData1;
    assign rd_data[1] = rf_readData2;
    assign rd_data[2] = rf_readData3;
    assign rd_data[3] = rf_readData4;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_READ;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane4
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    addr_reg[gi]     <= '0;
                    rsp_data_reg[gi] <= '0;
                end else begin
                    addr_reg[gi]     <= addr_next[gi];
                    rsp_data_reg[gi] <= rsp_data_next[gi];
                end
            end
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane2
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    data_reg[gi] <= '0;
                    tmp_reg[gi]  <= '0;
                end else begin
                    data_reg[gi] <= data_next[gi];
                    tmp_reg[gi]  <= tmp_next[gi];
                end
            end
        end
    endgenerate

`ifdef RFC_VERIFY_EN
    logic rsp_err_reg, rsp_err_next;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rsp_err_reg <= 1'b0;
        else         rsp_err_reg <= rsp_err_next;
    end
    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    // ------------------------------------------------- next state / outputs
    // rf_write is purely a function of state, so it is never asserted in a
    // cycle whose read data gets captured (EXEC of READ/COPY/SWAP, VERIFY);
    // that keeps the regfile bypass out of any capture path.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        for (int i = 0; i < 4; i++) begin
            addr_next[i]     = addr_reg[i];
            rsp_data_next[i] = rsp_data_reg[i];
        end
        for (int i = 0; i < 2; i++) begin
            data_next[i] = data_reg[i];
            tmp_next[i]  = tmp_reg[i];
        end
`ifdef RFC_VERIFY_EN
        rsp_err_next = rsp_err_reg;
`endif
        rf_write      = 1'b0;
        rf_writeReg1  = '0;
        rf_writeReg2  = '0;
        rf_writeData1 = '0;
        rf_writeData2 = '0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next = rfc_op_t'(cmd_op);
                    for (int i = 0; i < 4; i++) addr_next[i] = cmd_addr[i];
                    data_next[0] = cmd_data0;
                    data_next[1] = cmd_data1;
`ifdef RFC_VERIFY_EN
                    rsp_err_next = 1'b0;
`endif
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_reg)
                    OP_READ: begin
                        for (int i = 0; i < 4; i++) rsp_data_next[i] = rd_data[i];
                        state_next = ST_RESP;
                    end
                    OP_WRITE: begin
                        rf_write         = 1'b1;
                        rf_writeReg1     = addr_reg[0];
                        rf_writeData1    = data_reg[0];
                        rf_writeReg2     = addr_reg[1];
                        rf_writeData2    = data_reg[1];
                        rsp_data_next[0] = data_reg[0];
                        rsp_data_next[1] = data_reg[1];
                        rsp_data_next[2] = '0;
                        rsp_data_next[3] = '0;
`ifdef RFC_VERIFY_EN
                        state_next = ST_VERIFY;
`else
                        state_next = ST_RESP;
`endif
                    end
                    OP_COPY: begin
                        tmp_next[0] = rd_data[0];
                        state_next  = ST_WB;
                    end
                    default: begin // OP_SWAP
                        tmp_next[0] = rd_data[0];
                        tmp_next[1] = rd_data[1];
                        state_next  = ST_WB;
                    end
                endcase
            end
            ST_WB: begin
                rf_write = 1'b1;
                if (op_reg == OP_COPY) begin
                    // Both ports carry the same write so port 1 is effectively idle.
                    rf_writeReg1     = addr_reg[1];
                    rf_writeData1    = tmp_reg[0];
                    rf_writeReg2     = addr_reg[1];
                    rf_writeData2    = tmp_reg[0];
                    rsp_data_next[1] = '0;
                end else begin
                    // With addr0==addr1 port 2 wins and rewrites the old value.
                    rf_writeReg1     = addr_reg[0];
                    rf_writeData1    = tmp_reg[1];
                    rf_writeReg2     = addr_reg[1];
                    rf_writeData2    = tmp_reg[0];
                    rsp_data_next[1] = tmp_reg[1];
                end
                rsp_data_next[0] = tmp_reg[0];
                rsp_data_next[2] = '0;
                rsp_data_next[3] = '0;
                state_next       = ST_RESP;
            end
`ifdef RFC_VERIFY_EN
            ST_VERIFY: begin
                // Same-address write: port 2 data is what the register holds.
                rsp_err_next = (rd_data[0] != ((addr_reg[0] == addr_reg[1]) ? data_reg[1] : data_reg[0]))
                            || (rd_data[1] != data_reg[1]);
                state_next   = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign rsp_valid   = (state_reg == ST_RESP);
    assign rsp_data0   = rsp_data_reg[0];
    assign rsp_data1   = rsp_data_reg[1];
    assign rsp_data2   = rsp_data_reg[2];
    assign rsp_data3   = rsp_data_reg[3];
    assign rf_readReg1 = addr_reg[0];
    assign rf_readReg2 = addr_reg[1];
    assign rf_readReg3 = addr_reg[2];
    assign rf_readReg4 = addr_reg[3];

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_cmd_ctrl
//  Directed bench for rf_cmd_ctrl driving a behavioural 4R/2W regfile
//  (combinational write-bypassed reads, port 2 wins on equal addresses).
// -----------------------------------------------------------------------------
module tb_rf_cmd_ctrl;

    localparam logic [1:0] C_READ  = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_COPY  = 2'b10;
    localparam logic [1:0] C_SWAP  = 2'b11;
`ifdef RFC_VERIFY_EN
    localparam int WR_LAT = 3;
`else
    localparam int WR_LAT = 2;
`endif

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr0, cmd_addr1, cmd_addr2, cmd_addr3;
    logic [31:0] cmd_data0, cmd_data1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
    logic        rsp_err;
    logic        rf_write;
    logic [3:0]  rf_readReg1, rf_readReg2, rf_readReg3, rf_readReg4;
    logic [3:0]  rf_writeReg1, rf_writeReg2;
    logic [31:0] rf_writeData1, rf_writeData2;
    logic [31:0] rf_readData1, rf_readData2, rf_readData3, rf_readData4;

    rf_cmd_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr0     (cmd_addr0),
        .cmd_addr1     (cmd_addr1),
        .cmd_addr2     (cmd_addr2),
        .cmd_addr3     (cmd_addr3),
        .cmd_data0     (cmd_data0),
        .cmd_data1     (cmd_data1),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data0     (rsp_data0),
        .rsp_data1     (rsp_data1),
        .rsp_data2     (rsp_data2),
        .rsp_data3     (rsp_data3),
        .rsp_err       (rsp_err),
        .rf_write      (rf_write),
        .rf_readReg1   (rf_readReg1),
        .rf_readReg2   (rf_readReg2),
        .rf_readReg3   (rf_readReg3),
        .rf_readReg4   (rf_readReg4),
        .rf_writeReg1  (rf_writeReg1),
        .rf_writeReg2  (rf_writeReg2),
        .rf_writeData1 (rf_writeData1),
        .rf_writeData2 (rf_writeData2),
        .rf_readData1  (rf_readData1),
        .rf_readData2  (rf_readData2),
        .rf_readData3  (rf_readData3),
        .rf_readData4  (rf_readData4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------- regfile model
    logic [31:0] regs [16];
    logic        rf_clear;

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (rf_write) begin
            regs[rf_writeReg1] <= rf_writeData1;
            regs[rf_writeReg2] <= rf_writeData2;  // later NBA: port 2 wins
        end
    end

    function automatic logic [31:0] rf_lookup(input logic [3:0] a, input logic we,
                                              input logic [3:0] w1, input logic [31:0] d1,
                                              input logic [3:0] w2, input logic [31:0] d2,
                                              input logic [31:0] cur);
        if (we && w2 == a) return d2;
        if (we && w1 == a) return d1;
        return cur;
    endfunction

    assign rf_readData1 = rf_lookup(rf_readReg1, rf_write, rf_writeReg1, rf_writeData1,
                                    rf_writeReg2, rf_writeData2, regs[rf_readReg1]);
    assign rf_readData2 = rf_lookup(rf_readReg2, rf_write, rf_writeReg1, rf_writeData1,
                                    rf_writeReg2, rf_writeData2, regs[rf_readReg2]);
    assign rf_readData3 = rf_lookup(rf_readReg3, rf_write, rf_writeReg1, rf_writeData1,
                                    rf_writeReg2, rf_writeData2, regs[rf_readReg3]);
    assign rf_readData4 = rf_lookup(rf_readReg4, rf_write, rf_writeReg1, rf_writeData1,
                                    rf_writeReg2, rf_writeData2, regs[rf_readReg4]);

    // Free-running count of cycles with rf_write high (sampled mid-cycle).
    int wr_total;
    always @(negedge clk) if (rf_write) wr_total <= wr_total + 1;

    // ---------------------------------------------------- checking
    int          n_cmp;
    int          n_err;
    int          wr_mark;
    int          wr_cnt;
    int          rsp_lat;
    logic [31:0] rsp_cap [4];
    logic        rsp_err_cap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] a3,
                         input logic [31:0] d0, input logic [31:0] d1);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
        cmd_op    = op;
        cmd_addr0 = a0;
        cmd_addr1 = a1;
        cmd_addr2 = a2;
        cmd_addr3 = a3;
        cmd_data0 = d0;
        cmd_data1 = d1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wr_mark   = wr_total;
    endtask

    // Latency counts cycles from the accept cycle: READ=2, COPY/SWAP=3.
    task automatic wait_valid(input string name);
        rsp_lat = 1;
        while (!rsp_valid && rsp_lat < 20) begin
            @(posedge clk);
            #1;
            rsp_lat++;
        end
        if (!rsp_valid) check({name, "_rsp_timeout"}, {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic collect(input string name);
        wait_valid(name);
        rsp_cap[0]  = rsp_data0;
        rsp_cap[1]  = rsp_data1;
        rsp_cap[2]  = rsp_data2;
        rsp_cap[3]  = rsp_data3;
        rsp_err_cap = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        wr_cnt    = wr_total - wr_mark;
        $display("txn %s: lat=%0d data=%08h %08h %08h %08h err=%0b wr_cycles=%0d",
                 name, rsp_lat, rsp_cap[0], rsp_cap[1], rsp_cap[2], rsp_cap[3],
                 rsp_err_cap, wr_cnt);
    endtask

    task automatic txn(input string name, input logic [1:0] op,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [3:0] a3,
                       input logic [31:0] d0, input logic [31:0] d1);
        issue(op, a0, a1, a2, a3, d0, d1);
        collect(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------- stimulus
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        rf_clear  = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr0 = '0;
        cmd_addr1 = '0;
        cmd_addr2 = '0;
        cmd_addr3 = '0;
        cmd_data0 = '0;
        cmd_data1 = '0;
        rsp_ready = 1'b0;

        // 1: reset state
        #2;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rf_write", {31'b0, rf_write}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_data0", rsp_data0, 32'h0);
        check("rst_rsp_data1", rsp_data1, 32'h0);
        check("rst_rsp_data2", rsp_data2, 32'h0);
        check("rst_rsp_data3", rsp_data3, 32'h0);
        check("rst_wdata1", rf_writeData1, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn   = 1'b1;
        rf_clear = 1'b0;

        txn("read_0_5_10_15", C_READ, 4'd0, 4'd5, 4'd10, 4'd15, 32'h0, 32'h0);
        check("t1_lat", rsp_lat, 32'd2);
        check("t1_d0", rsp_cap[0], 32'h0);
        check("t1_d1", rsp_cap[1], 32'h0);
        check("t1_d2", rsp_cap[2], 32'h0);
        check("t1_d3", rsp_cap[3], 32'h0);

        // 2: dual write then read back
        txn("write_r1_r2", C_WRITE, 4'd1, 4'd2, 4'd0, 4'd0, 32'hAAAAAAAA, 32'hBBBBBBBB);
        check("t2w_lat", rsp_lat, WR_LAT);
        check("t2w_d0", rsp_cap[0], 32'hAAAAAAAA);
        check("t2w_d1", rsp_cap[1], 32'hBBBBBBBB);
        check("t2w_d2", rsp_cap[2], 32'h0);
        check("t2w_d3", rsp_cap[3], 32'h0);
        check("t2w_err", {31'b0, rsp_err_cap}, 32'd0);
        check("t2w_wr_cycles", wr_cnt, 32'd1);
        txn("read_1_2_0_2", C_READ, 4'd1, 4'd2, 4'd0, 4'd2, 32'h0, 32'h0);
        check("t2r_lat", rsp_lat, 32'd2);
        check("t2r_d0", rsp_cap[0], 32'hAAAAAAAA);
        check("t2r_d1", rsp_cap[1], 32'hBBBBBBBB);
        check("t2r_d2", rsp_cap[2], 32'h0);
        check("t2r_d3", rsp_cap[3], 32'hBBBBBBBB);

        // 3: same-address write, port 2 wins
        txn("write_r5_r5", C_WRITE, 4'd5, 4'd5, 4'd0, 4'd0, 32'hFACECAFE, 32'hDEADBEEF);
        check("t3w_d0", rsp_cap[0], 32'hFACECAFE);
        check("t3w_d1", rsp_cap[1], 32'hDEADBEEF);
        check("t3w_err", {31'b0, rsp_err_cap}, 32'd0);
        txn("read_5x4", C_READ, 4'd5, 4'd5, 4'd5, 4'd5, 32'h0, 32'h0);
        check("t3r_d0", rsp_cap[0], 32'hDEADBEEF);
        check("t3r_d1", rsp_cap[1], 32'hDEADBEEF);
        check("t3r_d2", rsp_cap[2], 32'hDEADBEEF);
        check("t3r_d3", rsp_cap[3], 32'hDEADBEEF);

        // 4: swap R1/R2
        txn("swap_r1_r2", C_SWAP, 4'd1, 4'd2, 4'd0, 4'd0, 32'h0, 32'h0);
        check("t4s_lat", rsp_lat, 32'd3);
        check("t4s_d0", rsp_cap[0], 32'hAAAAAAAA);
        check("t4s_d1", rsp_cap[1], 32'hBBBBBBBB);
        check("t4s_d2", rsp_cap[2], 32'h0);
        check("t4s_wr_cycles", wr_cnt, 32'd1);
        txn("read_1_2", C_READ, 4'd1, 4'd2, 4'd0, 4'd0, 32'h0, 32'h0);
        check("t4r_d0", rsp_cap[0], 32'hBBBBBBBB);
        check("t4r_d1", rsp_cap[1], 32'hAAAAAAAA);

        // 5: copy R2 -> R8
        txn("copy_r2_r8", C_COPY, 4'd2, 4'd8, 4'd0, 4'd0, 32'h0, 32'h0);
        check("t5c_lat", rsp_lat, 32'd3);
        check("t5c_d0", rsp_cap[0], 32'hAAAAAAAA);
        check("t5c_d1", rsp_cap[1], 32'h0);
        check("t5c_wr_cycles", wr_cnt, 32'd1);
        txn("read_8", C_READ, 4'd8, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0);
        check("t5r_d0", rsp_cap[0], 32'hAAAAAAAA);

        // same-register swap leaves it unchanged
        txn("swap_r5_r5", C_SWAP, 4'd5, 4'd5, 4'd0, 4'd0, 32'h0, 32'h0);
        check("t5s_d0", rsp_cap[0], 32'hDEADBEEF);
        check("t5s_d1", rsp_cap[1], 32'hDEADBEEF);
        txn("read_5", C_READ, 4'd5, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0);
        check("t5s_r5", rsp_cap[0], 32'hDEADBEEF);

        // 6a: backpressure holds the response
        issue(C_READ, 4'd1, 4'd2, 4'd8, 4'd5, 32'h0, 32'h0);
        wait_valid("hold_read");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("t6_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("t6_hold_d0", rsp_data0, 32'hBBBBBBBB);
            check("t6_hold_d3", rsp_data3, 32'hDEADBEEF);
            check("t6_hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            check("t6_hold_rf_write", {31'b0, rf_write}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        $display("txn hold_read: held 5 cycles, data0=%08h", rsp_data0);
        check("t6_after_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // 6b: reset during SWAP write-back
        issue(C_SWAP, 4'd1, 4'd2, 4'd0, 4'd0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("t6_wb_rf_write", {31'b0, rf_write}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_rf_write", {31'b0, rf_write}, 32'd0);
        check("t6_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("t6_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("t6_rst_rsp_data0", rsp_data0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        $display("txn swap_reset: reset asserted in WB");
        txn("read_1_2_post_rst", C_READ, 4'd1, 4'd2, 4'd0, 4'd0, 32'h0, 32'h0);
        check("t6_r1_kept", rsp_cap[0], 32'hBBBBBBBB);
        check("t6_r2_kept", rsp_cap[1], 32'hAAAAAAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
